// File: rtl/csr_exc_unit.sv
// csr_exc_unit: exception/privilege CSR block answering the writeback stage.
// Define CSR_TIMER_EN to build the TCFG/TVAL/TICLR timer; otherwise they read 0.
module csr_exc_unit #(
    parameter int TIMER_W = 32,
    parameter int HWI_N   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exc_valid,
    input  logic             exc_is_int,
    input  logic [6:0]       exc_ecode,
    input  logic             exc_tlbr,
    input  logic             wen_era,
    input  logic [31:0]      era_in,
    input  logic             wen_badv,
    input  logic [31:0]      badv_in,
    input  logic             wen_vppn,
    input  logic [18:0]      vppn_in,
    input  logic             ertn,
    input  logic [13:0]      csr_num,
    input  logic             csr_we,
    input  logic [31:0]      csr_wmask,
    input  logic [31:0]      csr_wdata,
    output logic [31:0]      csr_rdata,
    input  logic [HWI_N-1:0] hw_int,
    output logic             cpu_interrupt,
    output logic [31:0]      eentry,
    output logic [31:0]      tlbrentry,
    output logic [31:0]      csr_era,
    output logic             crmd_da,
    output logic             crmd_pg,
    output logic [1:0]       crmd_plv
);
    localparam logic [13:0] A_CRMD      = 14'h0000;
    localparam logic [13:0] A_PRMD      = 14'h0001;
    localparam logic [13:0] A_ECFG      = 14'h0004;
    localparam logic [13:0] A_ESTAT     = 14'h0005;
    localparam logic [13:0] A_ERA       = 14'h0006;
    localparam logic [13:0] A_BADV      = 14'h0007;
    localparam logic [13:0] A_EENTRY    = 14'h000C;
    localparam logic [13:0] A_TLBEHI    = 14'h0011;
    localparam logic [13:0] A_TCFG      = 14'h0041;
    localparam logic [13:0] A_TVAL      = 14'h0042;
    localparam logic [13:0] A_TICLR     = 14'h0044;
    localparam logic [13:0] A_TLBRENTRY = 14'h0088;

    function automatic logic [31:0] wmerge(input logic [31:0] old_v, input logic [31:0] wdata,
                                           input logic [31:0] wmask);
        return (old_v & ~wmask) | (wdata & wmask);
    endfunction

    logic [8:0]  crmd_r, crmd_n_s;
    logic [2:0]  prmd_r, prmd_n_s;
    logic [12:0] lie_r, lie_n_s;
    logic [1:0]  is_sw_r, is_sw_n_s;
    logic [7:0]  is_hw_r;
    logic [5:0]  ecode_r, ecode_n_s;
    logic        esub_r, esub_n_s;
    logic [31:0] era_r, era_n_s, badv_r, badv_n_s;
    logic [25:0] eentry_r, eentry_n_s, tlbrentry_r, tlbrentry_n_s;
    logic [18:0] vppn_r, vppn_n_s;
    logic        int_r, int_n_s;
    logic [12:0] is_all_s;
    logic [31:0] estat_s;
    logic        is_timer_r;

    logic sel_crmd_s, sel_prmd_s, sel_ecfg_s, sel_estat_s, sel_era_s, sel_badv_s;
    logic sel_eentry_s, sel_tlbehi_s, sel_tlbrentry_s;

    assign sel_crmd_s      = csr_we && (csr_num == A_CRMD);
    assign sel_prmd_s      = csr_we && (csr_num == A_PRMD);
    assign sel_ecfg_s      = csr_we && (csr_num == A_ECFG);
    assign sel_estat_s     = csr_we && (csr_num == A_ESTAT);
    assign sel_era_s       = csr_we && (csr_num == A_ERA);
    assign sel_badv_s      = csr_we && (csr_num == A_BADV);
    assign sel_eentry_s    = csr_we && (csr_num == A_EENTRY);
    assign sel_tlbehi_s    = csr_we && (csr_num == A_TLBEHI);
    assign sel_tlbrentry_s = csr_we && (csr_num == A_TLBRENTRY);

    // LIE bit 10 does not exist, so it is masked off on every write.
    assign lie_n_s   = sel_ecfg_s ? (((lie_r & ~csr_wmask[12:0]) | (csr_wdata[12:0] & csr_wmask[12:0]))
                                     & 13'h1BFF) : lie_r;
    assign is_sw_n_s = sel_estat_s ? ((is_sw_r & ~csr_wmask[1:0]) | (csr_wdata[1:0] & csr_wmask[1:0]))
                                   : is_sw_r;
    assign era_n_s   = wen_era  ? era_in  : (sel_era_s  ? wmerge(era_r,  csr_wdata, csr_wmask) : era_r);
    assign badv_n_s  = wen_badv ? badv_in : (sel_badv_s ? wmerge(badv_r, csr_wdata, csr_wmask) : badv_r);
    assign vppn_n_s  = wen_vppn ? vppn_in
                     : (sel_tlbehi_s ? ((vppn_r & ~csr_wmask[31:13]) | (csr_wdata[31:13] & csr_wmask[31:13]))
                                     : vppn_r);
    assign eentry_n_s = sel_eentry_s
                      ? ((eentry_r & ~csr_wmask[31:6]) | (csr_wdata[31:6] & csr_wmask[31:6])) : eentry_r;
    assign tlbrentry_n_s = sel_tlbrentry_s
                      ? ((tlbrentry_r & ~csr_wmask[31:6]) | (csr_wdata[31:6] & csr_wmask[31:6])) : tlbrentry_r;

    assign is_all_s = {1'b0, is_timer_r, 1'b0, is_hw_r, is_sw_r};
    assign estat_s  = {1'b0, 8'h00, esub_r, ecode_r, 3'b000, 1'b0, is_timer_r, 1'b0, is_hw_r, is_sw_r};
    assign int_n_s  = crmd_r[2] & (|(is_all_s & lie_r));

    // Privilege fields: exception beats ERTN beats software, only on the fields each one touches.
    always_comb begin
        crmd_n_s  = sel_crmd_s ? ((crmd_r & ~csr_wmask[8:0]) | (csr_wdata[8:0] & csr_wmask[8:0])) : crmd_r;
        prmd_n_s  = sel_prmd_s ? ((prmd_r & ~csr_wmask[2:0]) | (csr_wdata[2:0] & csr_wmask[2:0])) : prmd_r;
        ecode_n_s = ecode_r;
        esub_n_s  = esub_r;
        if (exc_valid) begin
            prmd_n_s       = crmd_r[2:0];
            crmd_n_s[2:0]  = 3'b000;
            crmd_n_s[4:3]  = exc_tlbr ? 2'b01 : crmd_n_s[4:3];
            ecode_n_s      = exc_is_int ? 6'd0 : exc_ecode[5:0];
            esub_n_s       = exc_is_int ? 1'b0 : exc_ecode[6];
        end else if (ertn) begin
            crmd_n_s[2:0]  = prmd_r;
            crmd_n_s[4:3]  = (ecode_r == 6'h3F) ? 2'b10 : crmd_n_s[4:3];
        end else begin
            ecode_n_s = ecode_r;
            esub_n_s  = esub_r;
        end
    end

    // Architectural CSR state and the registered interrupt request.
    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_r      <= 9'h008;
            prmd_r      <= 3'b000;
            lie_r       <= 13'h0000;
            is_sw_r     <= 2'b00;
            is_hw_r     <= 8'h00;
            ecode_r     <= 6'h00;
            esub_r      <= 1'b0;
            era_r       <= 32'h0;
            badv_r      <= 32'h0;
            eentry_r    <= 26'h0;
            tlbrentry_r <= 26'h0;
            vppn_r      <= 19'h0;
            int_r       <= 1'b0;
        end else begin
            crmd_r      <= crmd_n_s;
            prmd_r      <= prmd_n_s;
            lie_r       <= lie_n_s;
            is_sw_r     <= is_sw_n_s;
            is_hw_r     <= 8'(hw_int);
            ecode_r     <= ecode_n_s;
            esub_r      <= esub_n_s;
            era_r       <= era_n_s;
            badv_r      <= badv_n_s;
            eentry_r    <= eentry_n_s;
            tlbrentry_r <= tlbrentry_n_s;
            vppn_r      <= vppn_n_s;
            int_r       <= int_n_s;
        end
    end

`ifdef CSR_TIMER_EN
    logic [TIMER_W-1:0] tcfg_r, tcfg_n_s, tval_r, tval_n_s;
    logic               is_timer_n_s;
    logic               sel_tcfg_s, sel_ticlr_s;

    assign sel_tcfg_s  = csr_we && (csr_num == A_TCFG);
    assign sel_ticlr_s = csr_we && (csr_num == A_TICLR);

    // Timer: a TCFG write reloads TVAL and suppresses the countdown for that cycle.
    always_comb begin
        tcfg_n_s     = sel_tcfg_s ? ((tcfg_r & ~csr_wmask[TIMER_W-1:0]) | (csr_wdata[TIMER_W-1:0]
                                     & csr_wmask[TIMER_W-1:0])) : tcfg_r;
        tval_n_s     = tval_r;
        is_timer_n_s = (sel_ticlr_s && csr_wdata[0] && csr_wmask[0]) ? 1'b0 : is_timer_r;
        if (sel_tcfg_s) begin
            tval_n_s = {tcfg_n_s[TIMER_W-1:2], 2'b00};
        end else if (tcfg_r[0]) begin
            if (tval_r == '0) begin
                is_timer_n_s = 1'b1;
                tval_n_s     = tcfg_r[1] ? {tcfg_r[TIMER_W-1:2], 2'b00} : '0;
                tcfg_n_s[0]  = tcfg_r[1];
            end else begin
                tval_n_s = tval_r - TIMER_W'(1);
            end
        end else begin
            tval_n_s = tval_r;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg_r     <= '0;
            tval_r     <= '0;
            is_timer_r <= 1'b0;
        end else begin
            tcfg_r     <= tcfg_n_s;
            tval_r     <= tval_n_s;
            is_timer_r <= is_timer_n_s;
        end
    end
`else
    assign is_timer_r = 1'b0;
`endif

    // CSR read port; shows state from before the coming edge.
    always_comb begin
        csr_rdata = 32'h0;
        case (csr_num)
            A_CRMD:      csr_rdata = {23'h0, crmd_r};
            A_PRMD:      csr_rdata = {29'h0, prmd_r};
            A_ECFG:      csr_rdata = {19'h0, lie_r};
            A_ESTAT:     csr_rdata = estat_s;
            A_ERA:       csr_rdata = era_r;
            A_BADV:      csr_rdata = badv_r;
            A_EENTRY:    csr_rdata = {eentry_r, 6'h00};
            A_TLBEHI:    csr_rdata = {vppn_r, 13'h0000};
`ifdef CSR_TIMER_EN
            A_TCFG:      csr_rdata = 32'(tcfg_r);
            A_TVAL:      csr_rdata = 32'(tval_r);
`endif
            A_TLBRENTRY: csr_rdata = {tlbrentry_r, 6'h00};
            default:     csr_rdata = 32'h0;
        endcase
    end

    assign cpu_interrupt = int_r;
    assign eentry        = {eentry_r, 6'h00};
    assign tlbrentry     = {tlbrentry_r, 6'h00};
    assign csr_era       = era_r;
    assign crmd_da       = crmd_r[3];
    assign crmd_pg       = crmd_r[4];
    assign crmd_plv      = crmd_r[1:0];
endmodule
